// File: rtl/fetch_seq_pkg.sv
// Shared types and widths for the fetch sequencer: FSM state encoding,
// PC width, instruction size and branch-offset field widths.
package fetch_seq_pkg;

  localparam int PC_W         = 64;
  localparam int INSN_BYTES   = 4;
  localparam int COND_OFF_W   = 19;
  localparam int UNCOND_OFF_W = 26;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    REFILL = 2'b01,
    HALT   = 2'b10
  } fetch_state_e;

endpackage : fetch_seq_pkg

// File: rtl/fetch_sequencer_if.sv
// Bundle between the hazard unit / branch resolution (master) and the
// fetch sequencer (slave): stall/halt requests, branch outcome, fetch state.
interface fetch_sequencer_if;

  logic                                     stall_req;
  logic                                     halt_req;
  logic                                     br_valid;
  logic                                     br_taken;
  logic                                     br_uncond;
  logic                                     br_reg;
  logic [fetch_seq_pkg::PC_W-1:0]           br_pc;
  logic [fetch_seq_pkg::COND_OFF_W-1:0]     cond_addr19;
  logic [fetch_seq_pkg::UNCOND_OFF_W-1:0]   br_addr26;
  logic [fetch_seq_pkg::PC_W-1:0]           rd_val;

  logic [fetch_seq_pkg::PC_W-1:0]           pc;
  logic [fetch_seq_pkg::PC_W-1:0]           pc_plus4;
  logic                                     if_valid;
  logic                                     flush_ifid;
  logic                                     flush_idex;
  logic                                     halted;

  modport master (
    output stall_req, halt_req, br_valid, br_taken, br_uncond, br_reg,
           br_pc, cond_addr19, br_addr26, rd_val,
    input  pc, pc_plus4, if_valid, flush_ifid, flush_idex, halted
  );

  modport slave (
    input  stall_req, halt_req, br_valid, br_taken, br_uncond, br_reg,
           br_pc, cond_addr19, br_addr26, rd_val,
    output pc, pc_plus4, if_valid, flush_ifid, flush_idex, halted
  );

endinterface : fetch_sequencer_if

// File: rtl/branch_target_calc.sv
// Combinational branch target: BR takes the register value, otherwise the
// selected word offset is sign-extended, scaled to bytes and added to br_pc.
module branch_target_calc
  import fetch_seq_pkg::*;
(
  input  logic                    br_reg,
  input  logic                    br_uncond,
  input  logic [PC_W-1:0]         br_pc,
  input  logic [COND_OFF_W-1:0]   cond_addr19,
  input  logic [UNCOND_OFF_W-1:0] br_addr26,
  input  logic [PC_W-1:0]         rd_val,
  output logic [PC_W-1:0]         target
);

  logic [PC_W-1:0] cond_sext;
  logic [PC_W-1:0] uncond_sext;
  logic [PC_W-1:0] byte_offset;

  assign cond_sext   = {{(PC_W-COND_OFF_W){cond_addr19[COND_OFF_W-1]}}, cond_addr19};
  assign uncond_sext = {{(PC_W-UNCOND_OFF_W){br_addr26[UNCOND_OFF_W-1]}}, br_addr26};

  // Offsets are in words; the top two bits of the extended value fall off,
  // which keeps the sum modulo 2^64 like the PC itself.
  assign byte_offset = (br_uncond ? uncond_sext : cond_sext) << 2;
  assign target      = br_reg ? rd_val : br_pc + byte_offset;

endmodule : branch_target_calc

// File: rtl/fetch_sequencer.sv
// PC sequencer for the 5-stage pipeline: sequential fetch, stall, halt and
// branch redirect with a configurable number of refill bubbles afterwards.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned     REFILL_CYC = 1,
  parameter logic [PC_W-1:0] RESET_VEC  = '0
) (
  input  logic               clock,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] REFILL_CNT = CNT_W'(REFILL_CYC);
  localparam fetch_state_e     REDIR_ST   = (REFILL_CYC > 0) ? REFILL : RUN;

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PC_W-1:0]  pc_q,    pc_d;

  logic            redirect;
  logic [PC_W-1:0] target;

  branch_target_calc u_target (
    .br_reg      (bus.br_reg),
    .br_uncond   (bus.br_uncond),
    .br_pc       (bus.br_pc),
    .cond_addr19 (bus.cond_addr19),
    .br_addr26   (bus.br_addr26),
    .rd_val      (bus.rd_val),
    .target      (target)
  );

  assign redirect = bus.br_valid & (bus.br_reg | bus.br_taken);

  // NOTE: every always_comb output gets a default first so that no branch of
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;

    if (redirect) begin
      pc_d    = target;
      cnt_d   = REFILL_CNT;
      state_d = REDIR_ST;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.halt_req) begin
            state_d = HALT;
          end else if (!bus.stall_req) begin
            pc_d = pc_q + PC_W'(INSN_BYTES);
          end
        end
        // Refill counts down regardless of stall; halt from a bubble slot is bogus.
        REFILL: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HALT: ;
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // While reset is held the state register may still show pre-reset
  // contents, so the status outputs are forced to their reset values.
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + PC_W'(INSN_BYTES);
  assign bus.if_valid   = reset | (state_q == RUN);
  assign bus.halted     = ~reset & (state_q == HALT);
  assign bus.flush_ifid = ~reset & redirect;
  assign bus.flush_idex = ~reset & redirect;

endmodule : fetch_sequencer
